// File: rtl/fetch_pkg.sv
// Shared opcodes, branch condition codes and state encoding for the stage-0
// fetch/flow-control unit.
package fetch_pkg;

  localparam logic [4:0] OP_BRA  = 5'b00110;
  localparam logic [4:0] OP_JMP  = 5'b00111;
  localparam logic [4:0] OP_BSR  = 5'b10101;
  localparam logic [4:0] OP_RTS  = 5'b01000;
  localparam logic [4:0] OP_RTI  = 5'b01001;
  localparam logic [4:0] OP_LMSK = 5'b01110;

  typedef enum logic [2:0] {
    CC_Z  = 3'b000,
    CC_NZ = 3'b001,
    CC_N  = 3'b010,
    CC_NN = 3'b011,
    CC_C  = 3'b100,
    CC_NC = 3'b101,
    CC_AL = 3'b110,
    CC_NV = 3'b111
  } cond_e;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_HANDOFF = 4'd2,
    ST_OPND    = 4'd3,
    ST_DRAIN   = 4'd4,
    ST_EVAL    = 4'd5,
    ST_TGT     = 4'd6,
    ST_POP     = 4'd7,
    ST_INT     = 4'd8
  } state_e;

  function automatic logic cond_met(input logic [2:0] cc, input logic c,
                                    input logic n, input logic z);
    logic r;
    case (cc)
      CC_Z:    r = z;
      CC_NZ:   r = ~z;
      CC_N:    r = n;
      CC_NN:   r = ~n;
      CC_C:    r = c;
      CC_NC:   r = ~c;
      CC_AL:   r = 1'b1;
      CC_NV:   r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_branch_ctrl_ret_stack.sv
// Return-address stack with a registered top-of-stack output; push and pop
// in the same cycle overwrite the current top entry.
module ret_stack #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int SPW = $clog2(STACK_DEPTH);
  localparam logic [SPW:0]   SP_ONE   = (SPW+1)'(32'd1);
  localparam logic [SPW:0]   SP_TWO   = (SPW+1)'(32'd2);
  localparam logic [SPW:0]   SP_FULL  = (SPW+1)'(STACK_DEPTH);
  localparam logic [SPW-1:0] IDX_TWO  = SPW'(32'd2);

  logic [AW-1:0]  mem_q [STACK_DEPTH];
  logic [SPW:0]   sp_q;
  logic [AW-1:0]  top_q;
  logic [SPW:0]   sp_m1_s;
  logic [SPW-1:0] idx_below_s;

  assign sp_m1_s     = sp_q - SP_ONE;
  assign idx_below_s = sp_q[SPW-1:0] - IDX_TWO;
  assign full        = (sp_q == SP_FULL);
  assign empty       = (sp_q == {(SPW+1){1'b0}});
  assign dout        = top_q;

  // Stack storage, pointer and cached top entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      sp_q  <= {(SPW+1){1'b0}};
      top_q <= {AW{1'b0}};
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= {AW{1'b0}};
      end
    end else if (push && pop && !empty) begin
      mem_q[sp_m1_s[SPW-1:0]] <= din;
      top_q                   <= din;
    end else if (push && !full) begin
      mem_q[sp_q[SPW-1:0]] <= din;
      top_q                <= din;
      sp_q                 <= sp_q + SP_ONE;
    end else if (pop && !empty) begin
      sp_q  <= sp_m1_s;
      top_q <= (sp_q >= SP_TWO) ? mem_q[idx_below_s] : {AW{1'b0}};
    end else begin
      sp_q  <= sp_q;
      top_q <= top_q;
    end
  end

endmodule

// File: rtl/fetch_branch_ctrl.sv
// Stage-0 fetch/flow-control unit: owns the PC, hands plain instructions to
// stage 1 and executes branches, calls, returns, mask loads and interrupt entry.
module fetch_branch_ctrl
  import fetch_pkg::*;
#(
  parameter int            AW          = 8,
  parameter int            DW          = 8,
  parameter int            STACK_DEPTH = 4,
  parameter logic [AW-1:0] RST_VEC     = {AW{1'b0}},
  parameter logic [AW-1:0] INT_VEC     = AW'(8'hF0)
) (
  input  logic          clk,
  input  logic          clr,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] instr,
  input  logic [3:0]    flags,
  input  logic          s1_idle,
  output logic          s1_valid,
  input  logic          s1_ready,
  output logic [DW-1:0] s1_instr,
  input  logic          i_pending,
  output logic          int_ack,
  output logic          imask,
  output logic          stk_err,
  output logic [3:0]    state
);

  localparam logic [AW-1:0] PC_ONE = AW'(32'd1);
  localparam logic [AW-1:0] PC_TWO = AW'(32'd2);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [7:0]    ir_q, ir_d;
  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_instr_q, s1_instr_d;
  logic          int_ack_q, int_ack_d;
  logic          imask_q, imask_d;
  logic          stk_err_q, stk_err_d;

  logic          push_s, pop_s;
  logic [AW-1:0] push_din_s, stk_top_s;
  logic          stk_full_s, stk_empty_s;
  logic [AW-1:0] tgt_s;
  logic [4:0]    op_s;
  logic          unused_v_s;

  assign op_s       = ir_q[7:3];
  assign unused_v_s = flags[3];

  // The branch target is the second instruction word, truncated or zero-extended to the PC width.
  generate
    if (AW <= DW) begin : g_tgt_trunc
      assign tgt_s = instr[AW-1:0];
    end else begin : g_tgt_zext
      assign tgt_s = {{(AW-DW){1'b0}}, instr};
    end
  endgenerate

  ret_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stk (
    .clk   (clk),
    .clr   (clr),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_din_s),
    .dout  (stk_top_s),
    .full  (stk_full_s),
    .empty (stk_empty_s)
  );

  // Next-state, datapath and stack-control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    int_ack_d  = 1'b0;
    imask_d    = imask_q;
    stk_err_d  = stk_err_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    push_din_s = pc_q;

    case (state_q)
      ST_FETCH: begin
        if (i_pending && !imask_q) begin
          state_d   = ST_INT;
          int_ack_d = 1'b1;
        end else begin
          addr_d  = pc_q;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ir_d = instr[7:0];
        case (instr[7:3])
          OP_BRA, OP_JMP, OP_BSR: state_d = ST_OPND;
          OP_RTS, OP_RTI:         state_d = ST_DRAIN;
          OP_LMSK: begin
            imask_d = instr[0];
            pc_d    = pc_q + PC_ONE;
            state_d = ST_FETCH;
          end
          default: begin
            s1_valid_d = 1'b1;
            s1_instr_d = instr;
            state_d    = ST_HANDOFF;
          end
        endcase
      end
      ST_HANDOFF: begin
        if (s1_ready) begin
          s1_valid_d = 1'b0;
          pc_d       = pc_q + PC_ONE;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_HANDOFF;
        end
      end
      ST_OPND: begin
        addr_d = pc_q + PC_ONE;
        if (op_s == OP_BRA) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_TGT;
        end
      end
      // Flags are only trustworthy once stage 1 has retired everything it holds.
      ST_DRAIN: begin
        if (!s1_idle) begin
          state_d = ST_DRAIN;
        end else if (op_s == OP_BRA) begin
          state_d = ST_EVAL;
        end else begin
          state_d = ST_POP;
        end
      end
      ST_EVAL: begin
        if (cond_met(ir_q[2:0], flags[2], flags[1], flags[0])) begin
          pc_d = tgt_s;
        end else begin
          pc_d = pc_q + PC_TWO;
        end
        state_d = ST_FETCH;
      end
      ST_TGT: begin
        if (op_s == OP_BSR) begin
          push_din_s = pc_q + PC_TWO;
          push_s     = ~stk_full_s;
          stk_err_d  = stk_err_q | stk_full_s;
        end else begin
          push_s = 1'b0;
        end
        pc_d    = tgt_s;
        state_d = ST_FETCH;
      end
      ST_POP: begin
        if (stk_empty_s) begin
          stk_err_d = 1'b1;
          pc_d      = pc_q + PC_ONE;
        end else begin
          pop_s = 1'b1;
          pc_d  = stk_top_s;
          if (op_s == OP_RTI) begin
            imask_d = 1'b0;
          end else begin
            imask_d = imask_q;
          end
        end
        state_d = ST_FETCH;
      end
      ST_INT: begin
        push_din_s = pc_q;
        push_s     = ~stk_full_s;
        stk_err_d  = stk_err_q | stk_full_s;
        pc_d       = INT_VEC;
        imask_d    = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_FETCH;
      pc_q       <= RST_VEC;
      addr_q     <= RST_VEC;
      ir_q       <= 8'h00;
      s1_valid_q <= 1'b0;
      s1_instr_q <= {DW{1'b0}};
      int_ack_q  <= 1'b0;
      imask_q    <= 1'b1;
      stk_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      int_ack_q  <= int_ack_d;
      imask_q    <= imask_d;
      stk_err_q  <= stk_err_d;
    end
  end

  assign imem_addr = addr_q;
  assign s1_valid  = s1_valid_q;
  assign s1_instr  = s1_instr_q;
  assign int_ack   = int_ack_q;
  assign imask     = imask_q;
  assign stk_err   = stk_err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Directed bench for fetch_branch_ctrl: handoff, stall, branches, calls,
// interrupt entry/return, stack overflow/underflow and mid-run clear.
module tb_fetch_branch_ctrl;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_HANDOFF = 4'd2;
  localparam logic [3:0] S_OPND    = 4'd3;
  localparam logic [3:0] S_DRAIN   = 4'd4;
  localparam logic [3:0] S_EVAL    = 4'd5;
  localparam logic [3:0] S_INT     = 4'd8;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] imem_addr, instr, s1_instr;
  logic [3:0] flags, state;
  logic       s1_idle, s1_valid, s1_ready, i_pending, int_ack, imask, stk_err;
  logic [7:0] mem [256];
  int         n_assert = 0;
  int         n_fail   = 0;

  assign instr = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_branch_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .imem_addr (imem_addr),
    .instr     (instr),
    .flags     (flags),
    .s1_idle   (s1_idle),
    .s1_valid  (s1_valid),
    .s1_ready  (s1_ready),
    .s1_instr  (s1_instr),
    .i_pending (i_pending),
    .int_ack   (int_ack),
    .imask     (imask),
    .stk_err   (stk_err),
    .state     (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next DECODE cycle (bounded) and check the fetched address.
  task automatic run_to_decode(input string tag, input logic [7:0] exp_addr);
    int n;
    n = 0;
    tick();
    while (state !== S_DECODE && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_state"}, 32'(state), 32'(S_DECODE));
    check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03; mem[8'h03] = 8'h04;
    mem[8'h04] = 8'h70; mem[8'h05] = 8'h38; mem[8'h06] = 8'h10;
    mem[8'h10] = 8'h31; mem[8'h11] = 8'h40; mem[8'h12] = 8'h38; mem[8'h13] = 8'h20;
    mem[8'h20] = 8'hA8; mem[8'h21] = 8'h80; mem[8'h22] = 8'h38; mem[8'h23] = 8'h04;
    mem[8'h40] = 8'h38; mem[8'h41] = 8'h10; mem[8'h80] = 8'h40; mem[8'hF0] = 8'h48;
    mem[8'h50] = 8'hA8; mem[8'h51] = 8'h52; mem[8'h52] = 8'hA8; mem[8'h53] = 8'h54;
    mem[8'h54] = 8'hA8; mem[8'h55] = 8'h56; mem[8'h56] = 8'hA8; mem[8'h57] = 8'h58;
    mem[8'h58] = 8'hA8; mem[8'h59] = 8'h5A; mem[8'h5A] = 8'h40;

    clr = 1'b1; flags = 4'h0; s1_idle = 1'b1; s1_ready = 1'b1; i_pending = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_valid", 32'(s1_valid), 32'h0);
    check("rst_ack", 32'(int_ack), 32'h0);
    check("rst_imask", 32'(imask), 32'h1);
    check("rst_stkerr", 32'(stk_err), 32'h0);

    // Three plain words, three cycles each.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_addr", 32'(imem_addr), 32'(i));
      tick();
      check("seq_valid", 32'(s1_valid), 32'h1);
      check("seq_instr", 32'(s1_instr), 32'(i + 1));
      tick();
      check("seq_done", 32'(s1_valid), 32'h0);
      check("seq_fetch", 32'(state), 32'(S_FETCH));
    end

    // Handshake stall.
    s1_ready = 1'b0;
    tick();
    check("stall_addr", 32'(imem_addr), 32'h3);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_valid", 32'(s1_valid), 32'h1);
      check("stall_instr", 32'(s1_instr), 32'h04);
      check("stall_state", 32'(state), 32'(S_HANDOFF));
    end
    s1_ready = 1'b1;
    tick();
    check("stall_xfer", 32'(s1_valid), 32'h0);
    run_to_decode("after_stall", 8'h04);

    // LMSK 0.
    tick();
    check("lmsk_imask", 32'(imask), 32'h0);
    check("lmsk_state", 32'(state), 32'(S_FETCH));
    run_to_decode("jmp_src", 8'h05);
    run_to_decode("bra_src", 8'h10);

    // BRA NE taken with delayed s1_idle.
    s1_idle = 1'b0; flags = 4'b0000;
    tick();
    check("bra_opnd", 32'(state), 32'(S_OPND));
    tick();
    check("bra_opnd_addr", 32'(imem_addr), 32'h11);
    for (int i = 0; i < 4; i++) begin
      check("bra_drain", 32'(state), 32'(S_DRAIN));
      tick();
    end
    check("bra_drain_end", 32'(state), 32'(S_DRAIN));
    s1_idle = 1'b1;
    tick();
    check("bra_eval", 32'(state), 32'(S_EVAL));
    run_to_decode("bra_taken", 8'h40);

    // BRA NE not taken.
    run_to_decode("bra_src2", 8'h10);
    flags = 4'b0001;
    run_to_decode("bra_not_taken", 8'h12);

    // BSR / RTS.
    run_to_decode("bsr_src", 8'h20);
    run_to_decode("bsr_tgt", 8'h80);
    check("bsr_notempty", 32'(dut.u_stk.empty), 32'h0);
    run_to_decode("rts_ret", 8'h22);
    check("rts_empty", 32'(dut.u_stk.empty), 32'h1);
    check("rts_stkerr", 32'(stk_err), 32'h0);

    // Interrupt entry after LMSK 0, return via RTI.
    run_to_decode("lmsk2", 8'h04);
    i_pending = 1'b1;
    tick();
    check("int_pre_ack", 32'(int_ack), 32'h0);
    tick();
    check("int_state", 32'(state), 32'(S_INT));
    check("int_ack", 32'(int_ack), 32'h1);
    tick();
    check("int_ack_pulse", 32'(int_ack), 32'h0);
    check("int_imask", 32'(imask), 32'h1);
    i_pending = 1'b0;
    mem[8'h06] = 8'h50;
    run_to_decode("int_vec", 8'hF0);
    run_to_decode("rti_ret", 8'h05);
    check("rti_imask", 32'(imask), 32'h0);
    check("rti_empty", 32'(dut.u_stk.empty), 32'h1);

    // Five nested BSRs on a four-deep stack.
    run_to_decode("nest0", 8'h50);
    run_to_decode("nest1", 8'h52);
    run_to_decode("nest2", 8'h54);
    run_to_decode("nest3", 8'h56);
    run_to_decode("nest4", 8'h58);
    check("nest_full", 32'(dut.u_stk.full), 32'h1);
    check("nest_noerr", 32'(stk_err), 32'h0);
    run_to_decode("nest5", 8'h5A);
    check("ovf_stkerr", 32'(stk_err), 32'h1);
    mem[8'h52] = 8'h40; mem[8'h54] = 8'h40; mem[8'h56] = 8'h40; mem[8'h58] = 8'h40;
    mem[8'h53] = 8'h05;
    run_to_decode("pop4", 8'h58);
    run_to_decode("pop3", 8'h56);
    run_to_decode("pop2", 8'h54);
    run_to_decode("pop1", 8'h52);
    run_to_decode("pop_empty", 8'h53);
    check("unf_stkerr", 32'(stk_err), 32'h1);
    check("unf_empty", 32'(dut.u_stk.empty), 32'h1);

    // Clear in the middle of a handoff.
    s1_ready = 1'b0;
    tick();
    check("clr_pre_valid", 32'(s1_valid), 32'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_state", 32'(state), 32'(S_FETCH));
    check("clr_addr", 32'(imem_addr), 32'h0);
    check("clr_valid", 32'(s1_valid), 32'h0);
    check("clr_ack", 32'(int_ack), 32'h0);
    check("clr_imask", 32'(imask), 32'h1);
    check("clr_stkerr", 32'(stk_err), 32'h0);
    check("clr_empty", 32'(dut.u_stk.empty), 32'h1);
    s1_ready = 1'b1;
    run_to_decode("clr_restart", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_branch_ctrl.md
Name: fetch_branch_ctrl

Overview:
Parametrised stage-0 fetch/flow-control unit for the accumulator pipeline.
- Owns the program counter and fetches instruction words from instruction memory.
- Hands non-control instructions to stage 1 over a valid/ready handshake.
- Executes BRA, JMP, BSR, RTS, RTI and LMSK locally, using an internal return-address stack and maskable interrupt entry.
- Generalises the fixed 8-bit controller: configurable PC and word width, stack depth, and eight branch conditions over four flags.

Parameters:
AW, 8, program counter / address width
DW, 8, instruction word width (DW >= 8; opcode in bits [7:3], condition in [2:0])
STACK_DEPTH, 4, return-address stack entries (power of two, >= 2)
RST_VEC, 0, PC value after reset (AW bits)
INT_VEC, 'hF0, interrupt service entry address (AW bits)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous reset, active-high
imem_addr  out  AW  instruction memory address; registered; memory returns data one cycle later
instr  in  DW  instruction memory read data
flags  in  4  condition codes {V,C,N,Z} from stage 1
s1_idle  in  1  stage 1 has retired all handed-off instructions, so flags are final
s1_valid  out  1  instruction offered to stage 1
s1_ready  in  1  stage 1 accepts the offered instruction
s1_instr  out  DW  offered instruction word
i_pending  in  1  level interrupt request
int_ack  out  1  one-cycle pulse on interrupt entry
imask  out  1  interrupt mask; 1 = interrupts blocked
stk_err  out  1  sticky stack overflow/underflow flag
state  out  4  encoded current state, for debug

Behaviour:
Reset (clr=1 at a clock edge, also mid-operation):
- pc=RST_VEC, state=FETCH, s1_valid=0, int_ack=0, imask=1, stk_err=0.
- Stack pointer cleared; imem_addr=RST_VEC.

States:
- FETCH:
  - If i_pending && !imask: go to INT.
  - Otherwise drive imem_addr=pc and go to DECODE.
- DECODE: latch instr into ir, then dispatch on ir[7:3]:
  - BRA/JMP/BSR: go to OPND.
  - RTS/RTI: go to DRAIN.
  - LMSK: imask<=ir[0], pc<=pc+1, go to FETCH.
  - Anything else: s1_valid<=1, s1_instr<=ir, go to HANDOFF.
- HANDOFF:
  - Hold s1_valid and s1_instr stable until s1_ready.
  - On transfer: s1_valid<=0, pc<=pc+1, go to FETCH.
  - Throughput is one non-control instruction per 3 cycles with s1_ready tied high.
- OPND: imem_addr<=pc+1 to fetch the target word next cycle. BRA goes to DRAIN; JMP/BSR go to TGT.
- DRAIN: wait for s1_idle=1, because flags are valid only then. Next state: BRA to EVAL, RTS/RTI to POP.
- EVAL:
  - Target = instr[AW-1:0] (zero-extended if AW>DW).
  - Condition on ir[2:0]: 000 Z, 001 !Z, 010 N, 011 !N, 100 C, 101 !C, 110 always, 111 never.
  - True: pc<=target. False: pc<=pc+2.
  - Go to FETCH.
- TGT: target as in EVAL.
  - JMP: pc<=target.
  - BSR: push pc+2, then pc<=target.
  - Go to FETCH.
- POP:
  - pc<=top, sp decrements.
  - RTI additionally sets imask<=0.
  - Go to FETCH.
- INT:
  - Push pc, pc<=INT_VEC, imask<=1, int_ack=1 for this cycle only.
  - Go to FETCH.

Stack boundaries:
- Push when full: the push is dropped, stk_err<=1, and the PC update still occurs.
- Pop when empty: stk_err<=1 and pc<=pc+1.
- stk_err clears only on clr.

Other boundary rules:
- pc arithmetic wraps modulo 2^AW; pc+2 from 2^AW-1 gives 1.
- Interrupts are sampled only in FETCH, so a handoff is never aborted.
- i_pending rising during DRAIN or HANDOFF is serviced at the next FETCH.

Decomposition:
Shared package fetch_pkg:
- Opcode constants (BRA=5'b00110, JMP=5'b00111, BSR=5'b10101, RTS=5'b01000, RTI=5'b01001, LMSK=5'b01110).
- Condition codes.
- State encoding.

Sub-module ret_stack (params AW, STACK_DEPTH):
- Ports: clk, clr, push, pop, din, dout, full, empty.
- Registered top-of-stack output.
- Simultaneous push and pop replaces the top entry.

Test Plan:
- Reset, then 3 non-control words with s1_ready=1 -> imem_addr 0,1,2; each s1_valid pulse carries the matching word; 3 cycles per instruction.
- Handshake stall: s1_ready held low for 5 cycles during HANDOFF -> s1_valid and s1_instr stable, pc unchanged; transfer on the first s1_ready=1.
- BRA NE (0x31) at pc=0x10, target 0x40, s1_idle delayed 4 cycles: Z=0 -> pc=0x40; Z=1 -> pc=0x12; no EVAL before s1_idle.
- BSR at 0x20 to 0x80, then RTS at 0x80 -> pc sequence 0x20, 0x80, 0x22; stack empty afterwards.
- LMSK 0 then i_pending=1 at pc=0x05 -> int_ack one pulse, pc=INT_VEC, imask=1; RTI returns to 0x05 with imask=0.
- STACK_DEPTH=4 with 5 nested BSRs -> stk_err=1 after the 5th; RTS on an empty stack keeps stk_err=1; clr mid-HANDOFF -> all outputs at their reset values the next cycle.
